pwm_capture: RTL and testbench

Measures the high time and period of an external PWM/pulse input in system-clock cycles, the read side of the LED PWM drive path. Sits beside the iCE40 `SB_HFOSC` clock domain and feeds measured duty/period to blink and colour logic or a debug readout. It also serves as a loopback checker for our own PWM outputs. The input is asynchronous and is synchronised internally.

---
 rtl/pwm_capture.sv | 119 +++++++++++
 tb/tb_pwm_capture.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// ============================================================================
// Module   : pwm_capture
// Measures high time and rising-to-rising period of an asynchronous PWM input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_capture #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             stalled
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic             sync1_q, sync2_q, dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_tmp_q, high_q, period_q;
  logic             valid_q, stalled_q;
  state_t           state_q;

  logic w_rise, w_fall, w_timeout;

  // Flops reset high so an input already high at reset release is not a rise
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dly_q   <= 1'b1;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign w_rise    = sync2_q & ~dly_q;
  assign w_fall    = ~sync2_q & dly_q;
  assign w_timeout = (cnt_q == C_CNT_MAX);

  always_comb begin
    cnt_d = w_timeout ? cnt_q : cnt_q + C_CNT_ONE;
    if (w_rise) begin
      cnt_d = C_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_tmp_q  <= '0;
      high_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!sync2_q) begin
            state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_rise) begin
            state_q <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (w_timeout) begin
            state_q   <= S_IDLE;
            stalled_q <= 1'b1;
          end else if (w_fall) begin
            hi_tmp_q <= cnt_q;
            state_q  <= S_LOW;
          end
        end
        S_LOW: begin
          // Timeout wins so a period of all-ones is never published
          if (w_timeout) begin
            state_q   <= S_IDLE;
            stalled_q <= 1'b1;
          end else if (w_rise) begin
            high_q    <= hi_tmp_q;
            period_q  <= cnt_q;
            valid_q   <= 1'b1;
            stalled_q <= 1'b0;
            state_q   <= S_HIGH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign valid      = valid_q;
  assign stalled    = stalled_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
// Module   : tb_pwm_capture
// Segment-driven stimulus with a scoreboard of expected publishes for pwm_capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_capture;

  localparam int W    = 8;
  localparam int CMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pwm_in = 1'b1;
  logic [W-1:0] high_cnt, period_cnt;
  logic         valid, stalled;

  pwm_capture #(.CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .valid      (valid),
    .stalled    (stalled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int hi;
    int per;
    int due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model, in input-level time; states 0 idle, 1 armed, 2 high, 3 low
  int   m_state = 0;
  int   m_t     = 0;
  int   m_hi    = 0;
  int   m_stall = 0;
  int   m_lhi   = 0;
  int   m_lper  = 0;
  logic m_lvl   = 1'b1;

  task automatic seg(input logic lvl, input int n);
    if (lvl && !m_lvl) begin
      if (m_state == 1) begin
        m_state = 2;
      end else if (m_state == 3) begin
        if (m_t <= CMAX - 1) begin
          sbq.push_back('{hi: m_hi, per: m_t, due: cyc + 3});
          m_lhi   = m_hi;
          m_lper  = m_t;
          m_stall = 0;
        end
        m_state = 2;
      end
      m_t = 0;
    end else if (!lvl && m_lvl && m_state == 2) begin
      m_hi    = m_t;
      m_state = 3;
    end
    if (!lvl && m_state == 0) m_state = 1;
    m_lvl  = lvl;
    pwm_in = lvl;
    m_t   += n;
    if ((m_state == 2 || m_state == 3) && m_t >= CMAX) begin
      m_stall = 1;
      m_state = (!lvl && m_t >= CMAX + 2) ? 1 : 0;
    end
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulses(input int hi, input int lo, input int reps);
    for (int i = 0; i < reps; i++) begin
      seg(1'b1, hi);
      seg(1'b0, lo);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    m_state = 0;
    m_stall = 0;
    m_lhi   = 0;
    m_lper  = 0;
    m_lvl   = 1'b1;
    @(posedge clk);
    #1;
    check("rst_high_cnt", high_cnt, 0);
    check("rst_period_cnt", period_cnt, 0);
    check("rst_valid", valid, 0);
    check("rst_stalled", stalled, 0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("spurious_valid", valid, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("high_cnt", high_cnt, mon_e.hi);
        check("period_cnt", period_cnt, mon_e.per);
        check("valid_latency", cyc, mon_e.due);
        check("stalled_on_valid", stalled, 0);
      end
    end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
      check("valid_missing", valid, 1);
      void'(sbq.pop_front());
    end
  end

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    apply_reset();

    // Input high across reset release: no valid until low then two rises
    seg(1'b1, 6);
    seg(1'b0, 5);
    pulses(3, 5, 6);

    // Minimum pulse
    pulses(1, 1, 6);

    // Duty change, then an extended low
    pulses(3, 5, 3);
    pulses(6, 2, 3);
    seg(1'b1, 6);
    seg(1'b0, 5);
    pulses(6, 2, 2);

    // Random pulse trains
    for (int i = 0; i < 10; i++) begin
      seg(1'b1, $urandom_range(1, 20));
      seg(1'b0, $urandom_range(1, 20));
    end

    // 0 % duty stall with held results, then recovery
    pulses(10, 20, 3);
    seg(1'b0, 300);
    check("stall_low", stalled, m_stall);
    check("hold_high_cnt", high_cnt, m_lhi);
    check("hold_period_cnt", period_cnt, m_lper);
    pulses(10, 20, 3);
    check("recover_low", stalled, m_stall);

    // 100 % duty stall, then recovery
    seg(1'b1, 300);
    check("stall_high", stalled, m_stall);
    seg(1'b0, 10);
    pulses(4, 4, 4);
    check("recover_high", stalled, m_stall);

    // Reset in the middle of a high phase
    pulses(3, 5, 2);
    seg(1'b1, 4);
    apply_reset();
    seg(1'b1, 3);
    seg(1'b0, 5);
    pulses(3, 5, 4);

    repeat (8) @(posedge clk);
    #1;
    check("sb_drain", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
